// File: rtl/disc_reader_if.sv
// Acquisition-memory write port of the disc reader.
// The master (disc_reader) drives the timing byte and its one-tick write
// strobe; the slave (acquisition RAM side) reports when it cannot take
// another byte.
interface disc_reader_if;
  logic [7:0] mdat_out;
  logic       mwr;
  logic       mem_full;

  modport master (
    output mdat_out,
    output mwr,
    input  mem_full
  );

  modport slave (
    input  mdat_out,
    input  mwr,
    output mem_full
  );
endinterface

// File: rtl/disc_reader.sv
// disc_reader: flux-interval acquisition engine.
// Measures the tick count between rising edges of the read-data line and
// writes one timing byte per transition into acquisition memory. Bit 7 of
// each byte tags an index edge; intervals longer than CNT_MAX are split
// into carry bytes of value CNT_MAX.
// Optional build macro DISCREADER_GLITCHFILT_EN: rddata uses a 3-stage
// detector (pattern 011) so single-tick high pulses are ignored; every edge
// is seen one tick later, which leaves the measured intervals unchanged.
module disc_reader #(
  parameter int CNT_MAX   = 127,
  parameter int IDX_WIDTH = 6
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 clken,
  input  logic                 rddata,
  input  logic                 index,
  input  logic                 trkmark,
  input  logic                 start,
  input  logic                 abort,
  input  logic [1:0]           start_mode,
  input  logic [IDX_WIDTH-1:0] idx_stop,
  output logic                 running,
  output logic                 overrun,
  disc_reader_if.master        mem
);

  typedef enum logic [1:0] {
    S_IDLE       = 2'd0,
    S_WAIT_START = 2'd1,
    S_ACQ        = 2'd2
  } state_t;

  localparam logic [6:0] CARRY = 7'(CNT_MAX);

  state_t               state_q, state_d;
  logic [6:0]           cnt_q, cnt_d;
  logic                 edge_pend_q, edge_pend_d;
  logic                 idx_pend_q, idx_pend_d;
  logic [IDX_WIDTH-1:0] idxcnt_q, idxcnt_d;
  logic                 overrun_q, overrun_d;
  logic [7:0]           mdat_q, mdat_d;
  logic                 mwr_q, mwr_d;
  logic [1:0]           idx_sh;
  logic                 rd_edge;
  logic                 idx_edge;
  logic                 idx_bit;

`ifdef DISCREADER_GLITCHFILT_EN
  logic [2:0] rd_sh;
  assign rd_edge = (rd_sh == 3'b011);

  // Read-data history, oldest sample in the MSB; needs two highs to count.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)     rd_sh <= 3'b000;
    else if (clken) rd_sh <= {rd_sh[1:0], rddata};
  end
`else
  logic [1:0] rd_sh;
  assign rd_edge = (rd_sh == 2'b01);

  // Read-data history, oldest sample in the MSB.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)     rd_sh <= 2'b00;
    else if (clken) rd_sh <= {rd_sh[0], rddata};
  end
`endif

  assign idx_edge = (idx_sh == 2'b01);

  // Index history for rising-edge detection.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)     idx_sh <= 2'b00;
    else if (clken) idx_sh <= {idx_sh[0], index};
  end

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)     state_q <= S_IDLE;
    else if (clken) state_q <= state_d;
  end

  // Next state, emitted byte and counter updates for the current tick.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    edge_pend_d = edge_pend_q;
    idx_pend_d  = idx_pend_q;
    idxcnt_d    = idxcnt_q;
    overrun_d   = overrun_q;
    mdat_d      = mdat_q;
    mwr_d       = 1'b0;
    idx_bit     = idx_pend_q | idx_edge;

    case (state_q)
      S_IDLE: begin
        idxcnt_d = idx_stop;
        if (start) begin
          overrun_d   = 1'b0;
          edge_pend_d = 1'b0;
          idx_pend_d  = 1'b0;
          cnt_d       = 7'd1;
          if (start_mode == 2'b01 || start_mode == 2'b10) state_d = S_WAIT_START;
          else                                            state_d = S_ACQ;
        end
      end

      S_WAIT_START: begin
        cnt_d = 7'd1;
        if (abort) begin
          state_d = S_IDLE;
        end else if (start_mode == 2'b01 && idx_edge) begin
          // The arming index edge tags the first byte of the stream.
          idx_pend_d = 1'b1;
          state_d    = S_ACQ;
        end else if (start_mode == 2'b10 && trkmark) begin
          state_d = S_ACQ;
        end
      end

      S_ACQ: begin
        if (abort || mem.mem_full) begin
          state_d = S_IDLE;
          if (mem.mem_full) overrun_d = 1'b1;
        end else begin
          if (edge_pend_q) begin
            // Edge that landed on a carry tick: zero-length remainder byte.
            mdat_d      = {idx_bit, 7'd0};
            mwr_d       = 1'b1;
            edge_pend_d = 1'b0;
            cnt_d       = cnt_q + 7'd1;
          end else if (rd_edge && cnt_q < CARRY) begin
            mdat_d = {idx_bit, cnt_q};
            mwr_d  = 1'b1;
            cnt_d  = 7'd1;
          end else if (cnt_q == CARRY) begin
            mdat_d      = {idx_bit, CARRY};
            mwr_d       = 1'b1;
            cnt_d       = 7'd1;
            edge_pend_d = rd_edge;
          end else begin
            cnt_d = cnt_q + 7'd1;
          end

          if (mwr_d)         idx_pend_d = 1'b0;
          else if (idx_edge) idx_pend_d = 1'b1;

          // Index stop: this tick's byte still goes out, then back to idle.
          if (idx_edge && idxcnt_q != '0) begin
            idxcnt_d = idxcnt_q - IDX_WIDTH'(1);
            if (idxcnt_q == IDX_WIDTH'(1)) state_d = S_IDLE;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // Datapath and control registers; everything advances only on ticks.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_q       <= 7'd0;
      edge_pend_q <= 1'b0;
      idx_pend_q  <= 1'b0;
      idxcnt_q    <= '0;
      overrun_q   <= 1'b0;
      mdat_q      <= 8'd0;
      mwr_q       <= 1'b0;
    end else if (clken) begin
      cnt_q       <= cnt_d;
      edge_pend_q <= edge_pend_d;
      idx_pend_q  <= idx_pend_d;
      idxcnt_q    <= idxcnt_d;
      overrun_q   <= overrun_d;
      mdat_q      <= mdat_d;
      mwr_q       <= mwr_d;
    end
  end

  assign mem.mdat_out = mdat_q;
  assign mem.mwr      = mwr_q;
  assign running      = (state_q != S_IDLE);
  assign overrun      = overrun_q;

endmodule

// File: tb/tb_disc_reader.sv
// Directed bench for disc_reader: immediate/index/track-mark starts, carry
// bytes, edge-on-carry, index stop, mem_full overrun, clock-enable gaps,
// glitch filtering and asynchronous reset.
module tb_disc_reader;

`ifdef DISCREADER_GLITCHFILT_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 0;
`endif

  logic       clock = 1'b0;
  logic       reset;
  logic       clken;
  logic       rddata;
  logic       index;
  logic       trkmark;
  logic       start;
  logic       abort;
  logic [1:0] start_mode;
  logic [5:0] idx_stop;
  logic       running;
  logic       overrun;

  disc_reader_if mem_if ();

  disc_reader #(.CNT_MAX(127), .IDX_WIDTH(6)) dut (
    .clock      (clock),
    .reset      (reset),
    .clken      (clken),
    .rddata     (rddata),
    .index      (index),
    .trkmark    (trkmark),
    .start      (start),
    .abort      (abort),
    .start_mode (start_mode),
    .idx_stop   (idx_stop),
    .running    (running),
    .overrun    (overrun),
    .mem        (mem_if)
  );

  always #5 clock = ~clock;

  logic [7:0] cap[$];
  int n_asserts = 0;
  int n_fail    = 0;

  // Collect every written byte, sampled mid-cycle.
  always @(negedge clock) begin
    if (mem_if.mwr === 1'b1) cap.push_back(mem_if.mdat_out);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic ticks(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic gap(input int n);
    clken = 1'b0;
    repeat (n) begin
      @(posedge clock);
      #1;
    end
    clken = 1'b1;
  endtask

  // Two-tick high pulse; its edge is acted on 2+LAT ticks after it starts.
  task automatic rd_pulse();
    rddata = 1'b1;
    ticks(2);
    rddata = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    ticks(1);
    start = 1'b0;
  endtask

  task automatic stop_acq();
    abort = 1'b1;
    ticks(1);
    abort = 1'b0;
    cap.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; clken = 1'b1; rddata = 1'b0; index = 1'b0; trkmark = 1'b0;
    start = 1'b0; abort = 1'b0; start_mode = 2'b00; idx_stop = 6'd0;
    mem_if.mem_full = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_running", 32'(running), 0);
    chk("rst_overrun", 32'(overrun), 0);
    chk("rst_mwr", 32'(mem_if.mwr), 0);
    chk("rst_mdat", 32'(mem_if.mdat_out), 0);
    reset = 1'b1;
    ticks(2);
    chk("idle_running", 32'(running), 0);

    // Immediate mode, edges 10 ticks apart.
    do_start();
    chk("imm_running", 32'(running), 1);
    ticks(8 - LAT);
    repeat (3) begin
      rd_pulse();
      ticks(8);
    end
    chk("imm_count", 32'(cap.size()), 3);
    chk("imm_b0", 32'(cap[0]), 32'h0A);
    chk("imm_b1", 32'(cap[1]), 32'h0A);
    chk("imm_b2", 32'(cap[2]), 32'h0A);
    chk("imm_running2", 32'(running), 1);
    stop_acq();
    chk("abort_running", 32'(running), 0);

    // Clock-enable gap does not count toward the interval.
    do_start();
    ticks(3);
    gap(5);
    ticks(5 - LAT);
    rd_pulse();
    ticks(2);
    chk("clken_count", 32'(cap.size()), 1);
    chk("clken_b0", 32'(cap[0]), 32'h0A);
    stop_acq();

    // 300-tick interval: two carries then remainder 46.
    do_start();
    ticks(298 - LAT);
    rd_pulse();
    ticks(2);
    chk("long_count", 32'(cap.size()), 3);
    chk("long_b0", 32'(cap[0]), 32'h7F);
    chk("long_b1", 32'(cap[1]), 32'h7F);
    chk("long_b2", 32'(cap[2]), 32'h2E);
    stop_acq();

    // Edge on the carry tick, next edge 5 ticks later.
    do_start();
    ticks(125 - LAT);
    rd_pulse();
    ticks(3);
    rd_pulse();
    ticks(2);
    chk("coin_count", 32'(cap.size()), 3);
    chk("coin_b0", 32'(cap[0]), 32'h7F);
    chk("coin_b1", 32'(cap[1]), 32'h00);
    chk("coin_b2", 32'(cap[2]), 32'h05);
    stop_acq();

    // Start on index, stop after two index edges during acquisition.
    start_mode = 2'b01;
    idx_stop   = 6'd2;
    do_start();
    ticks(3);
    rd_pulse();
    ticks(3);
    chk("widx_nobytes", 32'(cap.size()), 0);
    chk("widx_running", 32'(running), 1);
    index = 1'b1; ticks(1); index = 1'b0;
    ticks(1);
    ticks(8 - LAT);
    rd_pulse();
    ticks(3 + LAT);
    index = 1'b1; ticks(1); index = 1'b0;
    ticks(3 - LAT);
    rd_pulse();
    ticks(1 + LAT);
    chk("istop_run_a", 32'(running), 1);
    index = 1'b1; ticks(1); index = 1'b0;
    chk("istop_run_b", 32'(running), 1);
    ticks(1);
    chk("istop_stopped", 32'(running), 0);
    rd_pulse();
    ticks(3);
    chk("istop_count", 32'(cap.size()), 2);
    chk("istop_b0", 32'(cap[0]), 32'h8A);
    chk("istop_b1", 32'(cap[1]), 32'h89);
    cap.delete();
    idx_stop = 6'd0;

    // Start on track mark.
    start_mode = 2'b10;
    do_start();
    ticks(4);
    chk("wtrk_running", 32'(running), 1);
    chk("wtrk_nobytes", 32'(cap.size()), 0);
    trkmark = 1'b1; ticks(1); trkmark = 1'b0;
    ticks(4 - LAT);
    rd_pulse();
    ticks(2);
    chk("trk_count", 32'(cap.size()), 1);
    chk("trk_b0", 32'(cap[0]), 32'h06);
    stop_acq();
    start_mode = 2'b00;

    // mem_full coincident with an edge: no write, overrun set.
    do_start();
    ticks(8 - LAT);
    rd_pulse();
    ticks(8);
    rddata = 1'b1;
    ticks(1 + LAT);
    mem_if.mem_full = 1'b1;
    ticks(1);
    mem_if.mem_full = 1'b0;
    rddata = 1'b0;
    chk("full_running", 32'(running), 0);
    chk("full_overrun", 32'(overrun), 1);
    ticks(3);
    chk("full_count", 32'(cap.size()), 1);
    chk("full_b0", 32'(cap[0]), 32'h0A);
    chk("full_sticky", 32'(overrun), 1);
    do_start();
    chk("restart_overrun", 32'(overrun), 0);
    chk("restart_running", 32'(running), 1);
    stop_acq();

    // Single-tick rddata pulse.
    do_start();
    ticks(5);
    rddata = 1'b1; ticks(1); rddata = 1'b0;
    ticks(8);
`ifdef DISCREADER_GLITCHFILT_EN
    chk("glitch_ignored", 32'(cap.size()), 0);
    rd_pulse();
    ticks(2);
    chk("glitch_pass_count", 32'(cap.size()), 1);
    chk("glitch_pass_b0", 32'(cap[0]), 32'h11);
`else
    chk("short_count", 32'(cap.size()), 1);
    chk("short_b0", 32'(cap[0]), 32'h07);
`endif
    stop_acq();

    // Asynchronous reset in the middle of acquisition.
    do_start();
    ticks(8 - LAT);
    rd_pulse();
    ticks(3);
    reset = 1'b0;
    #1;
    chk("arst_running", 32'(running), 0);
    chk("arst_mwr", 32'(mem_if.mwr), 0);
    chk("arst_mdat", 32'(mem_if.mdat_out), 0);
    rd_pulse();
    ticks(3);
    reset = 1'b1;
    ticks(3);
    chk("arst_count", 32'(cap.size()), 1);
    chk("arst_b0", 32'(cap[0]), 32'h0A);
    chk("arst_idle", 32'(running), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
